// File: rtl/serial_to_parallel_com_align_pkg.sv
// Shared definitions for the serial-to-parallel COM aligner.
//   ByteW   : deserialised byte width
//   ComChar : default alignment / idle symbol (K28.5-style COM)
//   state_e : aligner FSM state encoding
package serial_to_parallel_com_align_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic [ByteW-1:0] ComChar = 8'hBC;

  typedef enum logic [1:0] {
    StAlign  = 2'd0,
    StLock   = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/serial_to_parallel_com_align_s2p_shift_counter.sv
// Serial shift register plus 3-bit bit counter.
//   clk       : bit clock
//   reset     : synchronous active-high reset (clears shift register and counter)
//   clr_i     : synchronous clear of the bit counter (used while searching)
//   data_i    : serial input, MSB first
//   nxt_o     : byte completed on the current edge ({sr[6:0], data_i})
//   bit_cnt_o : current bit position; 7 marks a byte boundary
module s2p_shift_counter
  import serial_to_parallel_com_align_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             data_i,
  output logic [ByteW-1:0] nxt_o,
  output logic [2:0]       bit_cnt_o
);

  logic [ByteW-1:0] sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;

  assign sr_d      = {sr_q[ByteW-2:0], data_i};
  assign bit_cnt_d = clr_i ? 3'd0 : bit_cnt_q + 3'd1;

  assign nxt_o     = sr_d;
  assign bit_cnt_o = bit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/serial_to_parallel_com_align.sv
// Serial-to-parallel receive front end with COM-symbol byte alignment.
// Searches every bit position for COM_CHAR, then requires LOCK_COUNT consecutive
// boundary-aligned COMs before declaring the link active and emitting bytes.
//   clk       : bit clock, one serial bit per rising edge
//   reset     : synchronous active-high reset
//   data_in   : serial data, MSB first
//   data_out  : last deserialised byte in ACTIVE, held 8 cycles
//   valid_out : 1 when data_out is a non-COM data byte
//   active    : 1 once the link is aligned (sticky until reset)
module serial_to_parallel_com_align
  import serial_to_parallel_com_align_pkg::*;
#(
  parameter logic [ByteW-1:0] COM_CHAR   = ComChar,
  parameter int unsigned      LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  output logic [ByteW-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  state_e           state_q;
  logic [3:0]       com_cnt_q;
  logic [3:0]       com_cnt_inc;
  logic [ByteW-1:0] data_q;
  logic             valid_q;
  logic             active_q;

  logic [ByteW-1:0] nxt;
  logic [2:0]       bit_cnt;
  logic             boundary;
  logic             is_com;
  logic             cnt_clr;

  // Holding the counter at 0 throughout the search makes it 0 on the exit edge,
  // so the next boundary lands exactly 8 bits after the matching COM.
  assign cnt_clr = (state_q == StAlign);

  s2p_shift_counter u_shift_counter (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .data_i    (data_in),
    .nxt_o     (nxt),
    .bit_cnt_o (bit_cnt)
  );

  assign boundary    = (bit_cnt == 3'd7);
  assign is_com      = (nxt == COM_CHAR);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAlign;
      com_cnt_q <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StAlign: begin
          // Sliding search: any bit position may match.
          if (is_com) begin
            com_cnt_q <= 4'd1;
            if (LOCK_COUNT == 1) begin
              state_q  <= StActive;
              active_q <= 1'b1;
            end else begin
              state_q <= StLock;
            end
          end
        end
        StLock: begin
          if (boundary) begin
            if (is_com) begin
              com_cnt_q <= com_cnt_inc;
              if (com_cnt_inc == LockCnt) begin
                state_q  <= StActive;
                active_q <= 1'b1;
              end
            end else begin
              // Misaligned or broken COM run; search restarts on the next edge.
              com_cnt_q <= 4'd0;
              state_q   <= StAlign;
            end
          end
        end
        StActive: begin
          if (boundary) begin
            data_q  <= nxt;
            valid_q <= ~is_com;
          end
        end
        default: begin
          state_q <= StAlign;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_com_align.sv
module tb_serial_to_parallel_com_align;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst0, rst1;
  logic       din0, din1;
  logic [7:0] dout0, dout1;
  logic       vout0, vout1;
  logic       act0, act1;

  int unsigned n_pass;
  int unsigned n_chk;

  exp_t       sb[$];
  logic [7:0] hd[2];
  logic       hv[2];
  logic       ea[2];

  serial_to_parallel_com_align #(
    .COM_CHAR   (8'hBC),
    .LOCK_COUNT (4)
  ) u_dut4 (
    .clk       (clk),
    .reset     (rst0),
    .data_in   (din0),
    .data_out  (dout0),
    .valid_out (vout0),
    .active    (act0)
  );

  serial_to_parallel_com_align #(
    .COM_CHAR   (8'hBC),
    .LOCK_COUNT (1)
  ) u_dut1 (
    .clk       (clk),
    .reset     (rst1),
    .data_in   (din1),
    .data_out  (dout1),
    .valid_out (vout1),
    .active    (act1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] obs(input int sel);
    if (sel == 0) return {act0, dout0, vout0};
    return {act1, dout1, vout1};
  endfunction

  task automatic send_bit(input int sel, input logic b);
    if (sel == 0) din0 = b;
    else          din1 = b;
    @(posedge clk);
    #1;
  endtask

  // Drive one byte MSB first. If emit, the byte is expected on data_out after its
  // last bit; otherwise the outputs must hold their previous values throughout.
  task automatic send_byte(input int sel, input logic [7:0] b, input bit emit,
                           input logic exp_act);
    exp_t e;
    logic [9:0] o;
    if (emit) begin
      e.d = b;
      e.v = (b != 8'hBC);
      sb.push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(sel, b[i]);
      o = obs(sel);
      if (i != 0) begin
        n_chk++;
        if (o !== {ea[sel], hd[sel], hv[sel]})
          $display("FAIL hold byte=%h bit=%0d got act/data/valid=%b/%h/%b want %b/%h/%b",
                   b, i, o[9], o[8:1], o[0], ea[sel], hd[sel], hv[sel]);
        else n_pass++;
      end else begin
        ea[sel] = exp_act;
        if (emit) begin
          n_chk++;
          if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty byte=%h", b);
          end else begin
            e = sb.pop_front();
            hd[sel] = e.d;
            hv[sel] = e.v;
            n_pass++;
          end
        end
        n_chk++;
        if (o !== {ea[sel], hd[sel], hv[sel]})
          $display("FAIL boundary byte=%h got act/data/valid=%b/%h/%b want %b/%h/%b",
                   b, o[9], o[8:1], o[0], ea[sel], hd[sel], hv[sel]);
        else n_pass++;
      end
    end
  endtask

  task automatic do_reset(input int sel);
    logic [9:0] o;
    if (sel == 0) rst0 = 1'b1;
    else          rst1 = 1'b1;
    @(posedge clk);
    #1;
    if (sel == 0) rst0 = 1'b0;
    else          rst1 = 1'b0;
    hd[sel] = 8'h00;
    hv[sel] = 1'b0;
    ea[sel] = 1'b0;
    o = obs(sel);
    n_chk++;
    if (o !== 10'b0_0000_0000_0)
      $display("FAIL reset_state got act/data/valid=%b/%h/%b want 0/00/0", o[9], o[8:1], o[0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(0);
  endtask

  // 4xBC, then FF, DD: active rises on bit 32, FF after bit 40, DD after bit 48.
  task automatic test_lock_and_data();
    for (int k = 0; k < 4; k++) send_byte(0, 8'hBC, 1'b0, (k == 3));
    send_byte(0, 8'hFF, 1'b1, 1'b1);
    send_byte(0, 8'hDD, 1'b1, 1'b1);
  endtask

  task automatic test_idle_in_stream();
    send_byte(0, 8'h99, 1'b1, 1'b1);
    send_byte(0, 8'hBC, 1'b1, 1'b1);
    send_byte(0, 8'hAA, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_byte();
    logic [9:0] o;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    do_reset(0);
    for (int k = 0; k < 4; k++) send_byte(0, 8'hBC, 1'b0, (k == 3));
    send_byte(0, 8'h3C, 1'b1, 1'b1);
    o = obs(0);
    n_chk++;
    if (o[9] !== 1'b1) $display("FAIL relock_active got %b want 1", o[9]);
    else n_pass++;
  endtask

  // Reset asserted on the edge that would complete byte 12: the byte must be dropped.
  task automatic test_reset_on_boundary();
    logic [7:0] b;
    b = 8'h12;
    for (int i = 7; i >= 1; i--) send_bit(0, b[i]);
    din0 = b[0];
    do_reset(0);
  endtask

  task automatic test_misaligned_start();
    do_reset(0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(0, 8'hBC, 1'b0, (k == 3));
    send_byte(0, 8'hEE, 1'b1, 1'b1);
  endtask

  task automatic test_broken_lock();
    do_reset(0);
    send_byte(0, 8'hBC, 1'b0, 1'b0);
    send_byte(0, 8'hBC, 1'b0, 1'b0);
    send_byte(0, 8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(0, 8'hBC, 1'b0, (k == 3));
    send_byte(0, 8'hCC, 1'b1, 1'b1);
  endtask

  task automatic test_lock_count_one();
    do_reset(1);
    send_byte(1, 8'hBC, 1'b0, 1'b1);
    send_byte(1, 8'h77, 1'b1, 1'b1);
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    din0 = 1'b0;
    din1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      hd[i] = 8'h00;
      hv[i] = 1'b0;
      ea[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    test_reset();
    test_lock_and_data();
    test_idle_in_stream();
    test_reset_mid_byte();
    test_reset_on_boundary();
    test_misaligned_start();
    test_broken_lock();
    test_lock_count_one();

    n_chk++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
